fifo_rd_stream: RTL and testbench

- Downstream drain stage for sync_FIFO.
- Issues read strobes into the FIFO and absorbs its one-cycle registered read latency in a 2-entry buffer.
- Presents the data as a valid/ready stream, with a packet-boundary flag every PKT_LEN beats.
- Sits between sync_FIFO and any stream consumer. Guarantees no read-on-empty and no word loss under backpressure.

---
 rtl/fifo_rd_stream_pkg.sv | 21 ++
 rtl/stream_buf2.sv | 70 +++++++
 rtl/fifo_rd_stream.sv | 90 +++++++++
 tb/tb_fifo_rd_stream.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the fifo_rd_stream drain stage.
//   DATA_W_DEF  : default data width, matches the upstream FIFO word
//   PKT_LEN_DEF : default number of beats per packet
//   CNT_W_DEF   : default width of the popped-word counter
//   BUF_DEPTH   : entries in the read-latency buffer
//   OCC_W       : width of an occupancy count 0..BUF_DEPTH
package fifo_rd_stream_pkg;

  localparam int DATA_W_DEF  = 3;
  localparam int PKT_LEN_DEF = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int BUF_DEPTH   = 2;
  localparam int OCC_W       = $clog2(BUF_DEPTH + 1);

  // Width of a beat counter for packets of len beats; at least one bit so
  // a single-beat packet still has a legal (always-zero) counter.
  function automatic int beat_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry circular buffer that absorbs the FIFO's registered read latency.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   wr_en, wr_data  : store one word at the write pointer
//   pop             : retire the word at the read pointer
//   occ             : current occupancy (0..2)
//   rd_data         : word at the read pointer (head of the stream)
// The caller guarantees no write when full unless a pop happens in the same
// cycle, and no pop when empty.
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [DATA_W-1:0] mem_d [BUF_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Simultaneous write and pop leaves occupancy unchanged.
    occ_d = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the combinational block above uses blocking ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
      // NOTE: the storage is reset too, so m_data reads 0 out of reset instead
      // of stale contents; it is only two words, so a plain register array.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mem_q    <= mem_d;
    end
  end

  assign occ     = occ_q;
  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drain stage between sync_FIFO and a valid/ready stream consumer.
// Issues FIFO read strobes only when the word can be guaranteed a slot,
// buffers the one-cycle read latency, and flags every PKT_LEN-th beat.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   enable       : permits new FIFO reads (in-flight words always drain)
//   fifo_empty   : FIFO empty flag
//   fifo_data    : FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en    : FIFO read strobe
//   m_data/m_valid/m_ready/m_last : output stream
//   busy         : a word is in flight or buffered
//   pop_cnt      : words read from the FIFO, wrapping
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  pop_cnt
);

  localparam int BEAT_W = beat_width(PKT_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic              infl_q, infl_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [OCC_W-1:0]  occ;
  logic              pop;
  logic [OCC_W:0]    committed;

  stream_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (infl_q),
    .wr_data (fifo_data),
    .pop     (pop),
    .occ     (occ),
    .rd_data (m_data)
  );

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;

  // Slots already spoken for after this cycle's pop. A pop only happens with
  // occ >= 1, so the subtraction cannot underflow. Counting the pop here is
  // what lets a read issue in the same cycle a slot frees up (full rate).
  assign committed = {1'b0, occ} + (OCC_W + 1)'(infl_q) - (OCC_W + 1)'(pop);
  assign fifo_r_en = enable & ~fifo_empty & (committed < (OCC_W + 1)'(BUF_DEPTH));

  assign m_last  = m_valid & (beat_cnt_q == LAST_BEAT);
  assign busy    = infl_q | m_valid;
  assign pop_cnt = pop_cnt_q;

  always_comb begin
    infl_d     = fifo_r_en;
    beat_cnt_d = beat_cnt_q;
    pop_cnt_d  = pop_cnt_q + CNT_W'(fifo_r_en);
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_q     <= 1'b0;
      beat_cnt_q <= '0;
      pop_cnt_q  <= '0;
    end else begin
      infl_q     <= infl_d;
      beat_cnt_q <= beat_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  localparam int DATA_W  = 3;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data  = '0;
  logic              fifo_r_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic [CNT_W-1:0]  pop_cnt;

  fifo_rd_stream #(
    .DATA_W  (DATA_W),
    .PKT_LEN (PKT_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .pop_cnt    (pop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Bench FIFO (registered read) plus stream model.
  // A word read at the edge closing cycle t must be presented from cycle t+2;
  // words leave in read order; every PKT_LEN-th beat since reset is last.
  // ---------------------------------------------------------------------
  typedef struct {
    logic [DATA_W-1:0] data;
    int                iss;
  } word_t;

  logic [DATA_W-1:0] push_q[$];
  logic [DATA_W-1:0] fq[$];
  word_t             sb[$];
  int                cyc      = 0;
  int                beat_m   = 0;
  int                popcnt_m = 0;

  int                rd_pulses, ren_first, ren_last, beat_first, beat_last, last_cnt;
  logic [DATA_W-1:0] last_data;
  logic [DATA_W-1:0] got[$];

  always @(posedge clk or negedge rst) begin
    logic [DATA_W-1:0] d;
    if (!rst) begin
      sb.delete();
      fq.delete();
      beat_m     = 0;
      popcnt_m   = 0;
      fifo_empty <= 1'b1;
    end else begin
      cyc++;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        if (m_last) begin
          last_cnt++;
          last_data = m_data;
        end
        if (beat_first < 0) beat_first = cyc;
        beat_last = cyc;
        if (sb.size() > 0) void'(sb.pop_front());
        beat_m = (beat_m + 1) % PKT_LEN;
      end
      if (fifo_r_en) begin
        if (rd_pulses == 0) ren_first = cyc;
        ren_last = cyc;
        rd_pulses++;
        d = '0;
        if (fq.size() > 0) d = fq.pop_front();
        fifo_data <= d;
        sb.push_back('{d, cyc});
        popcnt_m = (popcnt_m + 1) % (1 << CNT_W);
      end
      while (push_q.size() > 0) fq.push_back(push_q.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_valid;
    if (!rst) begin
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_busy", busy, 0);
      check("rst_pop_cnt", pop_cnt, 0);
      check("rst_r_en", fifo_r_en, 0);
    end else begin
      exp_valid = (sb.size() > 0) && (cyc >= sb[0].iss + 1);
      check("m_valid", m_valid, exp_valid);
      if (exp_valid) begin
        check("m_data", m_data, sb[0].data);
        check("m_last", m_last, (beat_m == PKT_LEN - 1));
      end else begin
        check("m_last_idle", m_last, 0);
      end
      check("busy", busy, (sb.size() != 0));
      check("pop_cnt", pop_cnt, popcnt_m);
      check("read_on_empty", fifo_r_en & fifo_empty, 0);
      check("outstanding_le2", (sb.size() <= 2), 1);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    rd_pulses  = 0;
    ren_first  = -1;
    ren_last   = -1;
    beat_first = -1;
    beat_last  = -1;
    last_cnt   = 0;
    last_data  = '0;
    got.delete();
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    push_q.push_back(v);
  endtask

  task automatic apply_reset();
    enable  = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    clear_mon();
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((busy || fq.size() != 0 || push_q.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, (n < max_cyc), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] exp3[6];
    logic [DATA_W-1:0] exp5[4];
    int                n;
    exp3 = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
    exp5 = '{3'd5, 3'd6, 3'd7, 3'd0};

    // 1. Reset with FIFO empty.
    rst = 1'b0; enable = 1'b0; m_ready = 1'b0;
    clear_mon();
    repeat (3) tick();
    check("t1_m_data", m_data, 0);
    check("t1_m_valid", m_valid, 0);
    check("t1_pop_cnt", pop_cnt, 0);
    rst = 1'b1;
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (10) tick();
    check("t1_no_reads", rd_pulses, 0);
    check("t1_busy", busy, 0);

    // 2. Streaming five words at full rate.
    apply_reset();
    for (int i = 1; i <= 5; i++) push(DATA_W'(i));
    enable = 1'b1; m_ready = 1'b1;
    wait_drain("t2_drain_timeout", 50);
    check("t2_r_en_count", rd_pulses, 5);
    check("t2_r_en_consecutive", ren_last - ren_first, 4);
    check("t2_latency", beat_first - ren_first, 2);
    check("t2_beats_back_to_back", beat_last - beat_first, 4);
    check("t2_got_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("t2_data", got[i], i + 1);
    check("t2_last_count", last_cnt, 1);
    check("t2_last_data", last_data, 4);
    check("t2_pop_cnt", pop_cnt, 5);
    check("t2_busy_end", busy, 0);

    // 3. Backpressure with six words queued.
    apply_reset();
    for (int i = 0; i < 6; i++) push(exp3[i]);
    enable = 1'b1; m_ready = 1'b0;
    repeat (8) tick();
    check("t3_r_en_blocked", rd_pulses, 2);
    check("t3_valid_held", m_valid, 1);
    check("t3_head_data", m_data, 7);
    check("t3_busy", busy, 1);
    repeat (2) tick();
    check("t3_head_stable", m_data, 7);
    check("t3_last_stable", m_last, 0);
    m_ready = 1'b1;
    wait_drain("t3_drain_timeout", 50);
    check("t3_got_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("t3_data", got[i], exp3[i]);
    check("t3_no_gaps", beat_last - beat_first, 5);
    check("t3_pop_cnt", pop_cnt, 6);
    check("t3_last_data", last_data, 4);

    // 4. Enable dropped after the second read.
    apply_reset();
    for (int i = 1; i <= 4; i++) push(DATA_W'(i));
    enable = 1'b1; m_ready = 1'b1;
    n = 0;
    while (rd_pulses < 2 && n < 20) begin
      tick();
      n++;
    end
    enable = 1'b0;
    check("t4_two_reads_seen", (n < 20), 1);
    repeat (6) tick();
    check("t4_r_en_stopped", rd_pulses, 2);
    check("t4_delivered", got.size(), 2);
    check("t4_no_last_yet", last_cnt, 0);
    check("t4_idle_busy", busy, 0);
    enable = 1'b1;
    wait_drain("t4_drain_timeout", 50);
    check("t4_got_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t4_data", got[i], i + 1);
    check("t4_last_count", last_cnt, 1);
    check("t4_last_data", last_data, 4);

    // 5. Reset while words are in flight and buffered.
    apply_reset();
    for (int i = 1; i <= 6; i++) push(DATA_W'(i));
    enable = 1'b1; m_ready = 1'b0;
    n = 0;
    while (rd_pulses < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t5_loaded", (n < 20), 1);
    check("t5_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("t5_m_valid_now", m_valid, 0);
    check("t5_pop_cnt_now", pop_cnt, 0);
    check("t5_busy_now", busy, 0);
    check("t5_r_en_now", fifo_r_en, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    clear_mon();
    for (int i = 0; i < 4; i++) push(exp5[i]);
    m_ready = 1'b1;
    wait_drain("t5_drain_timeout", 50);
    check("t5_got_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t5_data", got[i], exp5[i]);
    check("t5_last_count", last_cnt, 1);
    check("t5_last_data", last_data, 0);
    check("t5_pop_cnt", pop_cnt, 4);

    // 6. Single word with a toggling consumer.
    apply_reset();
    push(3'd3);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    wait_drain("t6_drain_timeout", 30);
    check("t6_single_read", rd_pulses, 1);
    check("t6_got_count", got.size(), 1);
    if (got.size() > 0) check("t6_data", got[0], 3);
    check("t6_no_last", last_cnt, 0);
    check("t6_pop_cnt", pop_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
